// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet host bridge and its helpers.
package maxnet_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_LAUNCH,
    S_KICK,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int          EPS_SLOT = 0;
  localparam int          A1_SLOT  = 1;
  localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
  localparam int          ST_OVF   = 0;
  localparam int          ST_TMO   = 1;

endpackage

// File: rtl/maxnet_watchdog.sv
// Run watchdog: counts enabled cycles from a clear and flags when TIMEOUT_CYC-1 is reached.
module maxnet_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_reg, count_next;

  assign expired = (count_reg == CNT_W'(TIMEOUT_CYC - 1));

  // Saturates at expiry so a stalled caller never sees the count wrap.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !expired) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/maxnet_host_bridge.sv
// Host-side initiator for the 4-neuron Maxnet core: collects eps/a words, launches the core,
// waits for finish under a watchdog and returns the winner with sticky status.
module maxnet_host_bridge
  import maxnet_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_NEURONS   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic [DATA_W-1:0]             core_eps,
  output logic [N_NEURONS*DATA_W-1:0]   core_a,
  output logic                          core_load,
  output logic                          core_start,
  input  logic                          core_finish,
  input  logic [DATA_W-1:0]             core_out,
  input  logic                          core_overflow,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_W-1:0]             res_data,
  output logic [1:0]                    res_status
);

  localparam int N_SLOTS = N_NEURONS + 1;
  localparam int WIDX_W  = $clog2(N_SLOTS);

  state_t              state_reg, state_next;
  logic [WIDX_W-1:0]   widx_reg, widx_next;
  logic [DATA_W-1:0]   slot_reg [N_SLOTS];
  logic [DATA_W-1:0]   res_data_reg, res_data_next;
  logic [1:0]          status_reg, status_next;
  logic                res_valid_reg, res_valid_next;
  logic                wd_clear, wd_enable, wd_expired;
  logic                in_fire;

  assign in_ready   = (state_reg == S_LOAD);
  assign in_fire    = in_valid && in_ready;
  assign core_load  = (state_reg == S_LAUNCH);
  assign core_start = (state_reg == S_KICK);
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;
  assign res_status = status_reg;
  assign core_eps   = slot_reg[EPS_SLOT];

  generate
    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_core_a
      assign core_a[gi*DATA_W +: DATA_W] = slot_reg[A1_SLOT + gi];
    end
  endgenerate

  maxnet_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Slots are only writable in LOAD, so eps/a stay frozen for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (in_fire && (widx_reg == WIDX_W'(i))) begin
          slot_reg[i] <= in_data;
        end
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    widx_next     = widx_reg;
    res_data_next = res_data_reg;
    status_next   = status_reg;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;
    case (state_reg)
      S_LOAD: begin
        if (in_fire) begin
          if (widx_reg == WIDX_W'(N_NEURONS)) begin
            widx_next  = '0;
            state_next = S_LAUNCH;
          end else begin
            widx_next = widx_reg + WIDX_W'(1);
          end
        end
      end
      S_LAUNCH: begin
        wd_clear    = 1'b1;
        status_next = '0;
        state_next  = S_KICK;
      end
      S_KICK: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        wd_enable           = 1'b1;
        status_next[ST_OVF] = status_reg[ST_OVF] | core_overflow;
        // Finish takes priority over a simultaneous watchdog expiry.
        if (core_finish) begin
          res_data_next = core_out;
          state_next    = S_RESP;
        end else if (wd_expired) begin
          res_data_next       = '0;
          status_next[ST_TMO] = 1'b1;
          state_next          = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_next = S_LOAD;
        end
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
    res_valid_next = (state_next == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_LOAD;
      widx_reg      <= '0;
      res_data_reg  <= '0;
      status_reg    <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      widx_reg      <= widx_next;
      res_data_reg  <= res_data_next;
      status_reg    <= status_next;
      res_valid_reg <= res_valid_next;
    end
  end

endmodule

// File: tb/tb_maxnet_host_bridge.sv
// Directed bench for maxnet_host_bridge: load/launch sequencing, result handshake, status and watchdog.
module tb_maxnet_host_bridge;
  import maxnet_pkg::*;

  localparam int DATA_W = 32;
  localparam int NN     = 4;
  localparam int TMO    = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [DATA_W-1:0]  core_eps;
  logic [NN*DATA_W-1:0] core_a;
  logic               core_load;
  logic               core_start;
  logic               core_finish;
  logic [DATA_W-1:0]  core_out;
  logic               core_overflow;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;
  logic [1:0]         res_status;

  int errors = 0;
  int checks = 0;
  logic [31:0] words [5];

  always #5 clk = ~clk;

  maxnet_host_bridge #(
    .DATA_W(DATA_W),
    .N_NEURONS(NN),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .core_eps     (core_eps),
    .core_a       (core_a),
    .core_load    (core_load),
    .core_start   (core_start),
    .core_finish  (core_finish),
    .core_out     (core_out),
    .core_overflow(core_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_status   (res_status)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents words[0..n-1] with random idle gaps; leaves in_valid as last driven.
  task automatic load_words(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) step();
      end
      in_valid = 1'b1;
      in_data  = words[i];
      chk("in_ready_load", in_ready, 1'b1);
      step();
    end
  endtask

  // Called at the LAUNCH cycle; returns at the KICK cycle.
  task automatic launch_check();
    chk("in_ready_launch", in_ready, 1'b0);
    chk("core_load", core_load, 1'b1);
    chk("core_start_early", core_start, 1'b0);
    chk("core_eps", core_eps, words[0]);
    chk("core_a", core_a, {words[4], words[3], words[2], words[1]});
    step();
    chk("core_load_pulse", core_load, 1'b0);
    chk("core_start", core_start, 1'b1);
    chk("status_cleared", res_status, 2'b00);
  endtask

  task automatic run_to_finish(input int n, input logic [31:0] out);
    repeat (n) step();
    chk("res_valid_early", res_valid, 1'b0);
    core_finish = 1'b1;
    core_out    = out;
    step();
    core_finish = 1'b0;
    chk("res_valid", res_valid, 1'b1);
    chk("res_data", res_data, out);
  endtask

  task automatic handshake();
    $display("result data=%08h status=%02b", res_data, res_status);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 1'b0);
    chk("in_ready_idle", in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; core_finish = 1'b0;
    core_out = '0; core_overflow = 1'b0; res_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_core_load", core_load, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_status", res_status, 2'b00);
    chk("rst_core_eps", core_eps, 32'h0);
    chk("rst_core_a", core_a, 128'h0);
    rst_n = 1'b1;
    step();

    // Finish/overflow while loading must be ignored.
    core_finish = 1'b1; core_out = 32'h1234_5678; core_overflow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load_finish_ignored", res_valid, 1'b0);
      chk("load_finish_data", res_data, 32'h0);
    end
    core_finish = 1'b0; core_overflow = 1'b0;

    // Back-to-back load; a sixth word stays pending and is not consumed.
    words = '{32'h3E00_0000, FP_ONE, 32'h4000_0000, 32'h3F00_0000, 32'h3E80_0000};
    load_words(5, 0);
    in_data = 32'hDEAD_BEEF;
    launch_check();
    in_valid = 1'b0;

    // Finish 20 cycles after start; result held under back-pressure.
    run_to_finish(20, 32'h4000_0000);
    chk("res_status_clean", res_status, 2'b00);
    chk("eps_held", core_eps, words[0]);
    repeat (5) begin
      step();
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_data", res_data, 32'h4000_0000);
      chk("hold_status", res_status, 2'b00);
    end
    handshake();

    // One overflow pulse in WAIT sets the sticky bit.
    words = '{32'h3D00_0000, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3E00_0000};
    load_words(5, 0);
    in_valid = 1'b0;
    launch_check();
    repeat (3) step();
    core_overflow = 1'b1;
    step();
    core_overflow = 1'b0;
    run_to_finish(2, FP_ONE);
    chk("ovf_status", res_status, 2'b01);
    handshake();

    // Core never finishes: watchdog expiry.
    words = '{32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001, 32'h8000_0000, FP_ONE};
    load_words(5, 0);
    in_valid = 1'b0;
    launch_check();
    repeat (TMO) step();
    chk("tmo_valid_early", res_valid, 1'b0);
    step();
    chk("tmo_valid", res_valid, 1'b1);
    chk("tmo_data", res_data, 32'h0);
    chk("tmo_status", res_status, 2'b10);
    handshake();

    // Finish on the expiry cycle wins; NaN passes bit-exact.
    load_words(5, 0);
    in_valid = 1'b0;
    launch_check();
    run_to_finish(TMO, 32'h7FC0_0001);
    chk("expiry_finish_status", res_status, 2'b00);
    handshake();

    // Gapped load aborted by reset after the third word.
    words = '{32'h3E4C_CCCD, 32'h3F19_999A, 32'h3F4C_CCCD, 32'h3DCC_CCCD, 32'h3F66_6666};
    load_words(3, 2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_core_eps", core_eps, 32'h0);
    chk("arst_core_a", core_a, 128'h0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_res_valid", res_valid, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    load_words(5, 2);
    in_valid = 1'b0;
    launch_check();
    run_to_finish(4, 32'h3F66_6666);
    chk("post_rst_status", res_status, 2'b00);

    // Finish left high through the handshake and after it must not relaunch a result.
    core_finish = 1'b1;
    core_out    = 32'hCAFE_F00D;
    handshake();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_resp_finish_ignored", res_valid, 1'b0);
      chk("post_resp_data_held", res_data, 32'h3F66_6666);
    end
    core_finish = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
